apb_reg_slave_ctrl: RTL

- APB slave front-end that sits directly upstream of the 4-entry register file.
- Decodes APB setup/access phases, inserts a fixed number of wait states, and checks address range/alignment.
- Drives the register file's write-enable, address and write-data; returns the register file's combinational read data on PRDATA with PREADY/PSLVERR.
- Counts error responses for debug.

---
 rtl/apb_reg_slave_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/apb_reg_slave_ctrl.sv
// APB slave front-end for a 4-entry register file: setup/access decode, fixed wait
// states, address range/alignment check and a saturating error-response counter.
module apb_reg_slave_ctrl #(
    parameter int DW          = 32,
    parameter int AW          = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int CW          = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [AW-1:0] PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic          REG_WEN,
    output logic [AW-1:0] REG_ADDR,
    output logic [DW-1:0] REG_WDATA,
    input  logic [DW-1:0] REG_RDATA,
    output logic [CW-1:0] ERR_CNT
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          write_q;
    logic          addr_ok_q;
    logic          addr_ok;
    logic          done;

    // Only word offsets 0x0, 0x4, 0x8 and 0xC map onto the register file.
    assign addr_ok = (PADDR[AW-1:4] == '0) && (PADDR[1:0] == 2'b00);

    // Handshake: the master holds PSEL/PENABLE in ACCESS until PREADY=1; the transfer
    // (data, error, write strobe) takes effect only in that PREADY cycle. A reset in the
    // same cycle wins, so no completion is signalled.
    assign done    = (wait_cnt == 4'd0) && PSEL && PENABLE && !PRESET;
    assign PREADY  = (state == ACCESS) && done;
    assign PSLVERR = PREADY && !addr_ok_q;
    assign REG_WEN = PREADY && write_q && addr_ok_q;
    assign PRDATA  = (PREADY && !write_q && addr_ok_q) ? REG_RDATA : '0;

    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            addr_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q    <= PADDR;
                        wdata_q   <= PWDATA;
                        write_q   <= PWRITE;
                        addr_ok_q <= addr_ok;
                        wait_cnt  <= WAIT_INIT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Wait cycles count down even before PENABLE rises.
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (PENABLE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ERR_CNT <= '0;
        end else if (PSLVERR && (ERR_CNT != {CW{1'b1}})) begin
            ERR_CNT <= ERR_CNT + CW'(1);
        end
    end

endmodule
